// File: rtl/pe_result_collector_pkg.sv
// Shared types and helpers for the PE result collector: build-time defaults,
// the write-mode enum and a width-generic saturating adder.
package pe_collect_pkg;

  localparam int DEF_N_CH  = 8;
  localparam int DEF_WID   = 16;
  localparam int DEF_DEPTH = 4;

  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CH_W  = $clog2(DEF_N_CH);

  typedef enum logic {
    LOAD  = 1'b0,
    ACCUM = 1'b1
  } mode_e;

  // Operands arrive sign-extended to 64 bits; result is clamped to the signed
  // range of a w-bit word, so callers simply truncate back to w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/pe_result_collector_if.sv
// Write-side capture and read-side drain stream of the PE result collector.
interface pe_result_collector_if #(
  parameter int N_CH = 8,
  parameter int WID  = 16
);
  localparam int C_W = $clog2(N_CH);

  logic                  in_valid;
  logic                  in_accumulate;
  logic                  in_commit;
  logic signed [WID-1:0] data_in [N_CH-1:0];
  logic                  in_ready;

  logic                  out_valid;
  logic                  out_ready;
  logic signed [WID-1:0] out_data;
  logic [C_W-1:0]        out_ch;
  logic                  out_last;

  modport master (
    output in_valid, in_accumulate, in_commit, data_in, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );

  modport slave (
    input  in_valid, in_accumulate, in_commit, data_in, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );

endinterface

// File: rtl/pe_sat_add_vec.sv
// N_CH parallel signed saturating adders: open snapshot plus incoming PE vector.
module pe_sat_add_vec
  import pe_collect_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int WID  = DEF_WID
) (
  input  logic signed [WID-1:0] a_i   [N_CH-1:0],
  input  logic signed [WID-1:0] b_i   [N_CH-1:0],
  output logic signed [WID-1:0] sum_o [N_CH-1:0]
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign sum_o[g] = WID'(sat_add(64'(a_i[g]), 64'(b_i[g]), WID));
  end

endmodule

// File: rtl/pe_result_collector.sv
// DEPTH-deep ring of PE result snapshots with optional saturating accumulate,
// drained one channel per beat over a valid/ready stream.
module pe_result_collector
  import pe_collect_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int WID   = DEF_WID,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  pe_result_collector_if.slave     bus,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int P_W = $clog2(DEPTH);
  localparam int C_W = $clog2(N_CH);
  localparam logic [P_W:0]   FULL    = (P_W + 1)'(DEPTH);
  localparam logic [C_W-1:0] CH_LAST = C_W'(N_CH - 1);

  logic signed [WID-1:0] slot_q [DEPTH-1:0][N_CH-1:0];
  logic signed [WID-1:0] open_vec [N_CH-1:0];
  logic signed [WID-1:0] sum_vec  [N_CH-1:0];

  logic [P_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_W:0]   count_q, count_d;
  logic [C_W-1:0] ch_q, ch_d;
  logic           ovf_q, ovf_d;

  logic  wr_en, commit_en, beat, pop, ovf_evt;
  mode_e mode;

  assign mode = mode_e'(bus.in_accumulate);

  always_comb begin
    for (int i = 0; i < N_CH; i++) open_vec[i] = slot_q[wr_ptr_q][i];
  end

  pe_sat_add_vec #(.N_CH(N_CH), .WID(WID)) u_add (
    .a_i   (open_vec),
    .b_i   (bus.data_in),
    .sum_o (sum_vec)
  );

  assign bus.in_ready  = (count_q < FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.out_last  = bus.out_valid && (ch_q == CH_LAST);
  assign bus.out_ch    = ch_q;
  assign bus.out_data  = slot_q[rd_ptr_q][ch_q];
  assign count         = count_q;
  assign overflow      = ovf_q;

  // flush discards the whole cycle's write-side activity
  assign wr_en     = bus.in_valid && bus.in_ready && !flush;
  assign commit_en = bus.in_commit && bus.in_ready;
  assign beat      = bus.out_valid && bus.out_ready;
  assign pop       = beat && bus.out_last;
  assign ovf_evt   = (bus.in_valid || bus.in_commit) && !bus.in_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ch_d     = ch_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ch_d     = '0;
    end else begin
      if (commit_en) wr_ptr_d = wr_ptr_q + P_W'(1);
      if (beat)      ch_d     = pop ? '0 : ch_q + C_W'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + P_W'(1);
      case ({commit_en, pop})
        2'b10:   count_d = count_q + (P_W + 1)'(1);
        2'b01:   count_d = count_q - (P_W + 1)'(1);
        default: count_d = count_q;
      endcase
      if (ovf_evt)      ovf_d = 1'b1;
      else if (clr_err) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ch_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ch_q     <= ch_d;
      ovf_q    <= ovf_d;
    end
  end

  // Snapshot storage carries no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < N_CH; i++) begin
        slot_q[wr_ptr_q][i] <= (mode == ACCUM) ? sum_vec[i] : bus.data_in[i];
      end
    end
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector: directed scenarios plus random traffic
// against a snapshot-level reference model.
module tb_pe_result_collector;

  localparam int N_CH  = 4;
  localparam int WID   = 8;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       clr_err;
  logic [1:0] count;
  logic       overflow;

  pe_result_collector_if #(.N_CH(N_CH), .WID(WID)) bus ();

  pe_result_collector #(.N_CH(N_CH), .WID(WID), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .clr_err  (clr_err),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int ch;
    int last;
  } word_t;

  word_t exp_q[$];
  int    open_v [N_CH];
  bit    open_valid;
  int    pending;
  bit    m_ovf;
  bit    m_rdy;
  int    total;
  int    bad;

  function automatic int snaps();
    return (pending + N_CH - 1) / N_CH;
  endfunction

  function automatic int clamp(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: open snapshot vector plus a queue of expected output beats.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      pending    = 0;
      open_valid = 0;
      m_ovf      = 0;
    end else if (flush) begin
      exp_q.delete();
      pending    = 0;
      open_valid = 0;
    end else begin
      m_rdy = snaps() < DEPTH;
      if ((bus.in_valid || bus.in_commit) && !m_rdy) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (bus.out_ready && pending > 0) pending--;
      if (bus.in_valid && m_rdy) begin
        for (int i = 0; i < N_CH; i++)
          open_v[i] = bus.in_accumulate ? clamp(open_v[i] + int'(bus.data_in[i]))
                                        : int'(bus.data_in[i]);
        open_valid = 1;
      end
      if (bus.in_commit && m_rdy) begin
        for (int i = 0; i < N_CH; i++) begin
          word_t w;
          w.data = open_v[i];
          w.ch   = i;
          w.last = (i == N_CH - 1) ? 1 : 0;
          exp_q.push_back(w);
        end
        pending += N_CH;
        open_valid = 0;
      end
    end
  end

  // Monitor: compares the presented beat against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", bus.in_ready, (snaps() < DEPTH) ? 1 : 0);
      check("out_valid", bus.out_valid, (pending > 0) ? 1 : 0);
      check("count", count, snaps());
      check("overflow", overflow, m_ovf);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_without_expected", bus.out_valid, 0);
        end else begin
          check("out_data", bus.out_data, exp_q[0].data);
          check("out_ch", bus.out_ch, exp_q[0].ch);
          check("out_last", bus.out_last, exp_q[0].last);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_data(int a, int b, int c, int d);
    bus.data_in[0] = WID'(a);
    bus.data_in[1] = WID'(b);
    bus.data_in[2] = WID'(c);
    bus.data_in[3] = WID'(d);
  endtask

  task automatic step(bit v, bit acc, bit cm, bit ordy, bit fl, bit ce);
    bus.in_valid      = v;
    bus.in_accumulate = acc;
    bus.in_commit     = cm;
    bus.out_ready     = ordy;
    flush             = fl;
    clr_err           = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit ordy);
    for (int k = 0; k < n; k++) step(0, 0, 0, ordy, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_data(0, 0, 0, 0);
    bus.in_valid = 0; bus.in_accumulate = 0; bus.in_commit = 0; bus.out_ready = 0;
    flush = 0; clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_last", bus.out_last, 0);
    idle(2, 1);

    // load with commit, straight drain
    set_data(1, 2, 3, 4);
    step(1, 0, 1, 1, 0, 0);
    check("first_valid_after_commit", bus.out_valid, 1);
    idle(5, 1);
    check("drained_count", count, 0);

    // saturating accumulate in both directions
    set_data(100, -100, 5, 0);
    step(1, 0, 0, 1, 0, 0);
    set_data(50, -50, 5, -1);
    step(1, 1, 1, 1, 0, 0);
    idle(5, 1);

    // fill, overflow attempt, drain, clear error
    set_data(1, 1, 1, 1);
    step(1, 0, 1, 0, 0, 0);
    set_data(2, 2, 2, 2);
    step(1, 0, 1, 0, 0, 0);
    check("full_in_ready", bus.in_ready, 0);
    set_data(9, 9, 9, 9);
    step(1, 0, 0, 0, 0, 0);
    check("overflow_set", overflow, 1);
    idle(10, 1);
    step(0, 0, 0, 1, 0, 1);
    check("overflow_cleared", overflow, 0);

    // commit on the final beat of a drain with one free slot
    set_data(3, 3, 3, 3);
    step(1, 0, 1, 0, 0, 0);
    set_data(4, 4, 4, 4);
    step(1, 0, 1, 0, 0, 0);
    check("two_committed", count, 2);
    for (int k = 0; k < 20 && !(bus.out_last && count == 1); k++) step(0, 0, 0, 1, 0, 0);
    check("reached_last_with_one", bus.out_last && (count == 1), 1);
    set_data(5, 5, 5, 5);
    step(1, 0, 1, 1, 0, 0);
    check("count_held_on_pop_commit", count, 1);
    idle(6, 1);

    // flush mid-drain
    set_data(8, 8, 8, 8);
    step(1, 0, 1, 1, 0, 0);
    for (int k = 0; k < 10 && bus.out_ch != 2; k++) step(0, 0, 0, 1, 0, 0);
    check("reached_ch2", bus.out_ch, 2);
    step(0, 0, 0, 1, 1, 0);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_count", count, 0);
    check("flush_out_ch", bus.out_ch, 0);
    set_data(7, 7, 7, 7);
    step(1, 0, 1, 1, 0, 0);
    idle(5, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit v, acc, cm, ordy, fl, ce;
      for (int i = 0; i < N_CH; i++) begin
        case ($urandom_range(0, 3))
          0: bus.data_in[i] = 8'sh7f;
          1: bus.data_in[i] = 8'sh80;
          default: bus.data_in[i] = WID'($urandom_range(0, 255));
        endcase
      end
      v    = ($urandom_range(0, 1) == 1);
      acc  = open_valid && ($urandom_range(0, 2) != 0);
      cm   = ($urandom_range(0, 3) == 0) && (v || open_valid);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 80) == 0);
      ce   = ($urandom_range(0, 15) == 0);
      step(v, acc, cm, ordy, fl, ce);
    end

    for (int k = 0; k < 40 && pending > 0; k++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Parametrised successor to the PE array's dense output latch.
- Captures the per-PE result vector into a DEPTH-deep ring of snapshots.
- Optionally accumulates successive vectors into the open snapshot with signed saturation, for dense partial sums.
- Drains committed snapshots channel by channel over a valid/ready stream toward the output bus/writeback path.

Parameters:
- N_CH, 8: number of PE channels per snapshot.
- WID, 16: signed two's-complement data width per channel.
- DEPTH, 4: snapshot slots; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  data_in valid this cycle.
- in_accumulate  in  1  0 = load, 1 = saturating-add into open slot.
- in_commit  in  1  close open slot and push it to the drain queue.
- data_in  in  N_CH x WID  per-PE results, unpacked array [N_CH-1:0].
- in_ready  out  1  count < DEPTH.
- flush  in  1  synchronous clear of pointers, count and ch_idx.
- out_valid  out  1  count > 0.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WID  slot[rd_ptr][ch_idx].
- out_ch  out  $clog2(N_CH)  current channel index.
- out_last  out  1  out_valid && ch_idx == N_CH-1.
- count  out  $clog2(DEPTH)+1  committed slots.
- overflow  out  1  sticky error flag.
- clr_err  in  1  clears overflow.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=rd_ptr=0, count=0, ch_idx=0, overflow=0.
  - Outputs: out_valid=0, in_ready=1, out_last=0, out_ch=0.
  - Storage contents are don't-care; out_data is don't-care while out_valid=0.
- Write side, operating on slot[wr_ptr]:
  - in_valid && in_ready && !in_accumulate: slot <= data_in.
  - in_valid && in_ready && in_accumulate: per channel, slot <= sat(slot + data_in).
  - sat: compute the sum at WID+1 bits, clamp to [-2^(WID-1), 2^(WID-1)-1].
  - in_commit && in_ready: wr_ptr <= wr_ptr+1 (mod DEPTH), count increments.
  - Commit in the same cycle as in_valid includes that cycle's data.
  - Commit with no prior write commits the slot's stale contents.
- Write while full (in_valid or in_commit with in_ready=0):
  - Ignored: no storage write, no pointer change.
  - overflow <= 1.
- Read side:
  - out_data is combinational from storage, so out_valid rises the cycle after commit.
  - On out_valid && out_ready: ch_idx increments.
  - If out_last: ch_idx <= 0, rd_ptr increments (mod DEPTH), count decrements.
  - Outputs hold stable while out_valid && !out_ready.
- Simultaneous final pop and accepted commit: count unchanged, both pointers advance.
- Flush:
  - Same-cycle inputs are discarded.
  - Next cycle: count=0, ch_idx=0, wr_ptr=rd_ptr=0, out_valid=0.
  - overflow is preserved.
- Error clear: clr_err clears overflow unless an overflow event occurs in the same cycle, in which case set wins.
- rst has priority over flush, which has priority over all other inputs.
- Latency: commit-to-first-out 1 cycle; a full snapshot drains in N_CH cycles with out_ready held high.

Decomposition:
- Package pe_collect_pkg:
  - WID-generic sat_add function.
  - Localparams PTR_W=$clog2(DEPTH), CH_W=$clog2(N_CH).
  - Mode enum {LOAD, ACCUM}.
- Sub-module pe_sat_add_vec: N_CH parallel combinational saturating adders between data_in and slot[wr_ptr].
- The ring storage plus pointer/count control stays in the top block.

Test Plan (N_CH=4, WID=8, DEPTH=2):
- Reset, then idle -> out_valid=0, in_ready=1, count=0, overflow=0.
- Load {1,2,3,4} with commit in the same cycle, out_ready=1 -> next 4 cycles out_data=1,2,3,4, out_ch=0..3, out_last only on 4; count returns to 0.
- Load {100,-100,5,0}, then accumulate {50,-50,5,-1} with commit -> drained {127,-128,10,-1}.
- out_ready=0, commit {1,1,1,1} and {2,2,2,2} -> in_ready=0; a third load {9,9,9,9} sets overflow, storage unchanged; drain gives all 1s then all 2s; clr_err clears overflow.
- count=2, out_ready=1; on the out_last cycle apply an accepted commit (after one pop frees space) -> count stays constant that cycle and the order is preserved.
- Flush mid-drain at ch_idx=2 -> next cycle out_valid=0, count=0, out_ch=0; a following commit {7,7,7,7} drains correctly from slot 0.
